sobel_mag_sq_stream: RTL and testbench

SOBEL_MAG_SQ_STREAM -- requirements
Module: sobel_mag_sq_stream

---
 rtl/sobel_mag_sq_stream.sv | 151 +++++++++++++++
 tb/tb_sobel_mag_sq_stream.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_mag_sq_stream.sv
// sobel_mag_sq_stream
//   Streaming 3x3 Sobel filter. It returns the squared gradient magnitude,
//   saturated to 16 bits, so that a later 16-bit square-root stage can use it.
//   Pixels arrive in raster order. Gaps are allowed, and there is no backpressure.
//   A result is produced for every interior window centre. It appears exactly
//   3 cycles after the clock edge that accepts the window's bottom-right pixel.
//
// Ports
//   clk        single clock; all state changes on its rising edge
//   rst_n      asynchronous active-low reset
//   pix_valid  pix_in carries a pixel this cycle
//   pix_in     8-bit greyscale pixel
//   sof        start of frame (qualified by pix_valid); forces position (0,0)
//   R          min(ax*ax + ay*ay, 65535), where ax = |Gx|>>2 and ay = |Gy|>>2
//   R_valid    R is valid this cycle
//   R_eof      R is the last interior result of the frame
module sobel_mag_sq_stream #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_valid,
  input  logic [7:0]  pix_in,
  input  logic        sof,
  output logic [15:0] R,
  output logic        R_valid,
  output logic        R_eof
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0] col, cur_col;
  logic [RW-1:0] row, cur_row;
  logic          qualify, last_pix;

  // A pixel that carries sof is (0,0), whatever the counters say.
  always_comb begin
    cur_col  = sof ? '0 : col;
    cur_row  = sof ? '0 : row;
    qualify  = pix_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    last_pix = (cur_row == RW'(IMG_HEIGHT - 1)) && (cur_col == CW'(IMG_WIDTH - 1));
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples the value it had before the edge, with no dependence on
  // evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (pix_valid) begin
      if (cur_col == CW'(IMG_WIDTH - 1)) begin
        col <= '0;
        row <= last_pix ? '0 : cur_row + RW'(1);
      end else begin
        col <= cur_col + CW'(1);
        row <= cur_row;
      end
    end
  end

  // Line buffers and the 3x3 window. p[r][c]: r=2 is the current row and
  // c=2 is the newest column.
  logic [7:0] lb1 [IMG_WIDTH];   // row-1
  logic [7:0] lb2 [IMG_WIDTH];   // row-2
  logic [7:0] p   [3][3];

  // NOTE: the memories and the window have no reset. Stale contents are never
  // used, because the valid bits only rise once two full rows and two pixels
  // of the current frame have been accepted.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb1[cur_col] <= pix_in;
      lb2[cur_col] <= lb1[cur_col];
      for (int r = 0; r < 3; r++) begin
        p[r][0] <= p[r][1];
        p[r][1] <= p[r][2];
      end
      p[0][2] <= lb2[cur_col];
      p[1][2] <= lb1[cur_col];
      p[2][2] <= pix_in;
    end
  end

  // Gradient partial sums. The inputs are unsigned and each sum is at most
  // 1020, so it fits in 12 bits. The difference of two sums lies in +-1020.
  logic [11:0] gx_pos, gx_neg, gy_pos, gy_neg;

  // NOTE: every always_comb output gets a value on every path, so no latch
  // is inferred.
  always_comb begin
    gx_pos = 12'(p[0][2]) + {3'b0, p[1][2], 1'b0} + 12'(p[2][2]);
    gx_neg = 12'(p[0][0]) + {3'b0, p[1][0], 1'b0} + 12'(p[2][0]);
    gy_pos = 12'(p[2][0]) + {3'b0, p[2][1], 1'b0} + 12'(p[2][2]);
    gy_neg = 12'(p[0][0]) + {3'b0, p[0][1], 1'b0} + 12'(p[0][2]);
  end

  // Pipeline data registers. These advance every cycle; the valid bits below
  // decide what is used.
  logic signed [11:0] gx_q, gy_q;
  logic        [11:0] gx_abs, gy_abs;
  logic        [7:0]  ax, ay;
  logic        [15:0] sqx_q, sqy_q;
  logic        [16:0] sum;

  always_comb begin
    gx_abs = gx_q[11] ? 12'(-gx_q) : 12'(gx_q);
    gy_abs = gy_q[11] ? 12'(-gy_q) : 12'(gy_q);
    ax     = 8'(gx_abs >> 2);
    ay     = 8'(gy_abs >> 2);
    sum    = 17'(sqx_q) + 17'(sqy_q);
  end

  always_ff @(posedge clk) begin
    gx_q  <= $signed(gx_pos - gx_neg);
    gy_q  <= $signed(gy_pos - gy_neg);
    sqx_q <= 16'(ax) * 16'(ax);
    sqy_q <= 16'(ay) * 16'(ay);
  end

  // Valid and eof tags follow the data. Stage 0 is the window and stage 1
  // is Gx/Gy. Stage 2 holds the squares, and stage 3 is the output register R.
  logic v0, v1, v2, e0, e1, e2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0      <= 1'b0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      e0      <= 1'b0;
      e1      <= 1'b0;
      e2      <= 1'b0;
      R       <= '0;
      R_valid <= 1'b0;
      R_eof   <= 1'b0;
    end else begin
      v0      <= qualify;
      e0      <= qualify && last_pix;
      v1      <= v0;
      e1      <= e0;
      v2      <= v1;
      e2      <= e1;
      R_valid <= v2;
      R_eof   <= v2 && e2;
      if (v2) R <= sum[16] ? 16'hFFFF : sum[15:0];
    end
  end

endmodule

// File: tb/tb_sobel_mag_sq_stream.sv
// tb_sobel_mag_sq_stream
//   Directed bench for sobel_mag_sq_stream at 64x64. It uses these patterns:
//   constant, vertical step, diagonal, gapped input, mid-frame sof, and
//   mid-frame reset.
//   Each qualifying accept is queued together with its edge number and eof
//   flag. Every R_valid pulse must match the head of that queue.
//   Result values are checked as hand-derived counts per pattern.
module tb_sobel_mag_sq_stream;

  localparam int W = 64;
  localparam int H = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_valid = 1'b0;
  logic        sof = 1'b0;
  logic [7:0]  pix_in = '0;
  logic [15:0] R;
  logic        R_valid, R_eof;

  always #5 clk = ~clk;

  sobel_mag_sq_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_in(pix_in),
    .sof(sof), .R(R), .R_valid(R_valid), .R_eof(R_eof)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Count of rising edges so far. It is stable when read at a falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; bit eof; } exp_t;
  exp_t q[$];

  int brow = 0, bcol = 0;
  int n_pulse, n_eof, n_r0, n_r65025, n_r65535, n_r7938;
  logic [15:0] last_r;
  logic        last_eof;

  task automatic clear_stats();
    n_pulse = 0; n_eof = 0; n_r0 = 0; n_r65025 = 0; n_r65535 = 0; n_r7938 = 0;
    last_eof = 1'b0;
  endtask

  // Monitor: every pulse must be expected, arrive 3 edges after its accept,
  // and carry the right eof flag.
  always @(negedge clk) begin
    if (rst_n && R_valid === 1'b1) begin
      exp_t e;
      n_pulse++;
      last_r   = R;
      last_eof = R_eof;
      if (R_eof === 1'b1) n_eof++;
      case (R)
        16'd0:     n_r0++;
        16'd65025: n_r65025++;
        16'd65535: n_r65535++;
        16'd7938:  n_r7938++;
        default: ;
      endcase
      check("pulse_expected", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("latency", 32'(cyc - e.cyc), 32'd3);
        check("eof_flag", 32'(R_eof), 32'(e.eof));
      end
    end
  end

  // Pixel patterns: 0 = constant 100, 1 = vertical step at col 32,
  // 2 = diagonal (row+col >= 40), 3 = constant 50.
  function automatic logic [7:0] img(input int mode, input int r, input int c);
    case (mode)
      0:       return 8'd100;
      1:       return (c < 32) ? 8'd0 : 8'd255;
      2:       return (r + c >= 40) ? 8'd255 : 8'd0;
      default: return 8'd50;
    endcase
  endfunction

  task automatic px(input int mode, input bit s);
    @(negedge clk);
    pix_valid = 1'b1;
    sof       = s;
    if (s) begin brow = 0; bcol = 0; end
    pix_in = img(mode, brow, bcol);
    if (brow >= 2 && bcol >= 2) q.push_back('{cyc + 1, (brow == H - 1 && bcol == W - 1)});
    if (bcol == W - 1) begin
      bcol = 0;
      brow = (brow == H - 1) ? 0 : brow + 1;
    end else begin
      bcol++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_valid = 1'b0;
      sof       = 1'b0;
    end
  endtask

  task automatic frame(input int mode, input int gap, input bit first_sof);
    for (int i = 0; i < W * H; i++) begin
      px(mode, first_sof && i == 0);
      if (gap > 0) idle(gap);
    end
    idle(6);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_stats();
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_R", 32'(R), 32'd0);
    check("rst_R_valid", 32'(R_valid), 32'd0);
    check("rst_R_eof", 32'(R_eof), 32'd0);
    rst_n = 1'b1;

    // Constant frame: every result is 0, with one eof on the last pulse
    clear_stats();
    frame(0, 0, 1'b1);
    check("const_pulses", n_pulse, 3844);
    check("const_zero", n_r0, 3844);
    check("const_eof", n_eof, 1);
    check("const_last_eof", 32'(last_eof), 32'd1);
    check("const_queue", q.size(), 0);

    // Vertical step: centres at cols 31 and 32 give 65025, 2 per row x 62 rows
    clear_stats();
    frame(1, 0, 1'b1);
    check("vstep_pulses", n_pulse, 3844);
    check("vstep_65025", n_r65025, 124);
    check("vstep_zero", n_r0, 3720);
    check("vstep_eof", n_eof, 1);
    check("vstep_queue", q.size(), 0);

    // Hold: the last result is the centre (1,31), which is 65025. A following
    // non-qualifying pixel changes the window but must leave R unchanged.
    clear_stats();
    for (int i = 0; i < 2 * W + 33; i++) px(1, i == 0);
    idle(8);
    check("hold_pulses", n_pulse, 31);
    check("hold_65025", n_r65025, 1);
    check("hold_R", 32'(R), 32'd65025);
    check("hold_R_valid", 32'(R_valid), 32'd0);
    px(1, 1'b1);
    idle(8);
    check("hold_R_after_pix", 32'(R), 32'd65025);

    // Diagonal: centres with r+c = 39 or 40 saturate (38+39), those with
    // r+c = 38 or 41 give 7938 (37+40), and all others give 0
    clear_stats();
    frame(2, 0, 1'b1);
    check("diag_pulses", n_pulse, 3844);
    check("diag_sat", n_r65535, 77);
    check("diag_7938", n_r7938, 77);
    check("diag_zero", n_r0, 3690);
    check("diag_eof", n_eof, 1);

    // Gapped input: one pixel every 3rd cycle. Latency is checked per pulse.
    clear_stats();
    frame(1, 2, 1'b1);
    check("gap_pulses", n_pulse, 3844);
    check("gap_65025", n_r65025, 124);
    check("gap_eof", n_eof, 1);
    check("gap_queue", q.size(), 0);

    // sof at old (30,10). The old frame gives 28*62 + 8 = 1744 results,
    // then the new frame gives 3844.
    clear_stats();
    for (int i = 0; i < 30 * W + 10; i++) px(3, i == 0);
    frame(3, 0, 1'b1);
    check("sof_pulses", n_pulse, 1744 + 3844);
    check("sof_zero", n_r0, 1744 + 3844);
    check("sof_eof", n_eof, 1);
    check("sof_last_eof", 32'(last_eof), 32'd1);
    check("sof_queue", q.size(), 0);

    // Mid-frame reset with results in flight. R currently holds the centre
    // (19,31), which is 65025.
    for (int i = 0; i < 20 * W + 36; i++) px(1, i == 0);
    @(negedge clk);
    pix_valid = 1'b0;
    sof       = 1'b0;
    check("pre_reset_R", 32'(R), 32'd65025);
    #1 rst_n = 1'b0;
    q.delete();
    #1;
    check("midrst_R", 32'(R), 32'd0);
    check("midrst_R_valid", 32'(R_valid), 32'd0);
    check("midrst_R_eof", 32'(R_eof), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    brow = 0;
    bcol = 0;
    clear_stats();
    frame(0, 0, 1'b0);
    check("rst_frame_pulses", n_pulse, 3844);
    check("rst_frame_zero", n_r0, 3844);
    check("rst_frame_eof", n_eof, 1);
    check("rst_frame_last_eof", 32'(last_eof), 32'd1);
    check("rst_frame_queue", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
